// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aes_pkg
// Description : Shared AES-128 key schedule definitions: round count, Rcon
//               table, S-box lookup, word helpers and controller state type.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  // Controller states.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_e;

  // Rcon indexed by round number; entry 0 and 11..15 are unused and zero.
  localparam logic [0:15][7:0] RCON =
    128'h00_01_02_04_08_10_20_40_80_1b_36_00_00_00_00_00;

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    return RCON[r];
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_round.sv
`default_nettype none
// ============================================================================
// Module      : key_round
// Description : Combinational AES-128 key schedule step: derives round key r
//               from round key r-1.
// Revision    : 1.0 - initial release
// ============================================================================
module key_round
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [3:0]   round_i,
  output logic [127:0] next_key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_i;

  // Only the first word sees the S-box; the rest ripple through XOR chain.
  assign t  = sub_word(rot_word(w3)) ^ {rcon(round_i), 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key_o = {n0, n1, n2, n3};

endmodule
`default_nettype wire

// File: rtl/key_expansion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_expansion_ctrl
// Description : Iterative AES-128 key expansion, one round key per cycle,
//               with an 11-entry round-key store and combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module key_expansion_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [3:0]   rk_sel,
  output logic [127:0] rk_out,
  output logic         busy,
  output logic         done,
  output logic         keys_valid
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         valid_q, valid_d;
  logic         load, step;
  logic [127:0] prev_key;
  logic [127:0] next_key;
  logic [127:0] rk_q [0:NUM_ROUNDS];

  // Control registers; reset abandons any expansion in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic: start is only honoured in IDLE; the counter holds at the last round.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          round_d = 4'd1;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (round_q == LAST_ROUND) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Previous round key feeding the schedule step; guarded so the index stays in range.
  always_comb begin
    prev_key = '0;
    if (round_q != 4'd0 && round_q <= LAST_ROUND) begin
      prev_key = rk_q[round_q - 4'd1];
    end
  end

  key_round u_key_round (
    .key_i      (prev_key),
    .round_i    (round_q),
    .next_key_o (next_key)
  );

  // Round-key store: cipher key on load, one derived key per EXPAND cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        rk_q[i] <= '0;
      end
    end else if (load) begin
      rk_q[0] <= key_in;
    end else if (step) begin
      rk_q[round_q] <= next_key;
    end
  end

  // Read port; indices past the last round key read as zero.
  always_comb begin
    rk_out = '0;
    if (rk_sel <= LAST_ROUND) begin
      rk_out = rk_q[rk_sel];
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = valid_q;

endmodule
`default_nettype wire

// File: doc/key_expansion_ctrl.md
KEY_EXPANSION_CTRL -- requirements
Module: key_expansion_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 10, meaning the number of AES-128 round keys generated after the cipher key.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a one-cycle request to expand key_in.
REQ-005 The block SHALL have port key_in, input, 128, the cipher key; word w0 = [127:96] through w3 = [31:0].
REQ-006 The block SHALL have port rk_sel, input, 4, the round-key read index 0..10.
REQ-007 The block SHALL have port rk_out, output, 128, the stored round key selected by rk_sel.
REQ-008 The block SHALL have port busy, output, 1, high while expansion is in progress.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse when round key 10 has been written.
REQ-010 The block SHALL have port keys_valid, output, 1, a level meaning all 11 stored round keys belong to the last accepted key.

Function
REQ-011 The block SHALL have states IDLE and EXPAND.
REQ-012 In IDLE, start=1 SHALL store key_in into rk[0], set round=1 and busy=1, clear keys_valid, and enter EXPAND on the same edge.
REQ-013 In EXPAND, each edge SHALL write rk[round] = expand(rk[round-1], round) and then increment round; exactly one round is computed per cycle.
REQ-014 expand(k, r) SHALL compute t = SubWord(RotWord(k.w3)) ^ {Rcon[r], 24'h0}, w0' = k.w0^t, w1' = k.w1^w0', w2' = k.w2^w1', w3' = k.w3^w2'.
REQ-015 RotWord SHALL rotate the 32-bit word left by 8 bits, and SubWord SHALL apply the AES S-box to each byte.
REQ-016 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-017 On the edge that writes rk[NUM_ROUNDS], the block SHALL return to IDLE, set done=1 and keys_valid=1, and clear busy.
REQ-018 done SHALL be high for exactly one cycle.
REQ-019 Latency SHALL be fixed: with start sampled at edge E0, done SHALL be high from E10 to E11, and busy SHALL be high from E0 to E10.
REQ-020 start while busy=1 SHALL be ignored, with no effect on state, round keys or outputs.
REQ-021 start in IDLE while keys_valid=1 SHALL restart expansion, and keys_valid SHALL fall on that edge.
REQ-022 rk_out SHALL be a combinational read of rk[rk_sel].
REQ-023 rk_sel values 11..15 SHALL return all zeros.
REQ-024 Reads during EXPAND SHALL return the current register contents, which may be stale.
REQ-025 The round counter SHALL be 4 bits and SHALL never exceed NUM_ROUNDS; it does not wrap.

Reset
REQ-026 reset=0 SHALL immediately force IDLE, round=0, busy=0, done=0 and keys_valid=0, and SHALL clear rk[0..10] to zero.
REQ-027 Reset asserted mid-EXPAND SHALL abandon the expansion, and no done pulse SHALL follow.
REQ-028 After reset deassertion, the first rising edge SHALL be able to accept start.

Structure
REQ-029 Package aes_pkg SHALL hold NUM_ROUNDS, the Rcon table, the S-box function, and the state typedef {IDLE, EXPAND}.
REQ-030 One sub-module, key_round, SHALL be purely combinational, take inputs (key 128, round 4), and output the next key per REQ-014; the controller SHALL instantiate it once.
REQ-031 Round-key storage SHALL be an 11 x 128 register array inside the controller.

Verification
REQ-032 Bench SHALL cover: key_in=2b7e151628aed2a6abf7158809cf4f3c, start at E0 -> rk[1]=a0fafe1788542cb123a339392a6c7605, rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6, done high E10..E11 only.
REQ-033 Bench SHALL cover: start pulsed again at E3 with a different key -> ignored, and final keys match REQ-032.
REQ-034 Bench SHALL cover: reset low at E5 -> busy=0, keys_valid=0, rk_out=0 for all rk_sel, and no done pulse within the next 20 cycles.
REQ-035 Bench SHALL cover: key_in all zeros -> rk[1]=62636363626363636263636362636363, rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-036 Bench SHALL cover: rk_sel=11 and rk_sel=15 after completion -> rk_out=0.
REQ-037 Bench SHALL cover: restart after keys_valid=1 -> keys_valid falls on the start edge and rises with the new done pulse.
